// File: rtl/act_out_writer.sv
// Activation output writer: takes DESIGN_SIZE-lane vectors and writes them to BRAM at base + n*stride.
// Optional running XOR checksum enabled by defining ACT_OUT_CKSUM_EN.
module act_out_writer #(
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned DESIGN_SIZE = 4,
    parameter int unsigned AWIDTH      = 10,
    parameter int unsigned MASK_WIDTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [AWIDTH-1:0]             base_addr,
    input  logic [AWIDTH-1:0]             addr_stride,
    input  logic [7:0]                    num_vectors,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] in_data,
    input  logic                          in_data_available,
    input  logic [MASK_WIDTH-1:0]         validity_mask,
    output logic [AWIDTH-1:0]             bram_addr,
    output logic [DESIGN_SIZE*DWIDTH-1:0] bram_wdata,
    output logic [DESIGN_SIZE-1:0]        bram_we,
    output logic                          busy,
    output logic                          done,
    output logic                          drop_err,
    output logic [DESIGN_SIZE*DWIDTH-1:0] checksum
);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e                        state_q, state_d;
    logic [AWIDTH-1:0]             ptr_q, ptr_d;
    logic [AWIDTH-1:0]             stride_q, stride_d;
    logic [7:0]                    rem_q, rem_d;
    logic [AWIDTH-1:0]             addr_q, addr_d;
    logic [DESIGN_SIZE*DWIDTH-1:0] wdata_q, wdata_d;
    logic [DESIGN_SIZE-1:0]        we_q, we_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          drop_q, drop_d;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        stride_d = stride_q;
        rem_d    = rem_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = '0;
        drop_d   = drop_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (num_vectors != 8'd0) begin
                        ptr_d    = base_addr;
                        stride_d = addr_stride;
                        rem_d    = num_vectors;
                        state_d  = StRun;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StRun: begin
                if (in_data_available) begin
                    addr_d  = ptr_q;
                    wdata_d = in_data;
                    we_d    = DESIGN_SIZE'(validity_mask);
                    ptr_d   = ptr_q + stride_q;
                    rem_d   = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = StFin;
                    end
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Only RUN consumes data; anything else arriving is lost.
        if (in_data_available && (state_q != StRun)) begin
            drop_d = 1'b1;
        end
        busy_d = (state_d != StIdle);
        done_d = (state_d == StFin);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            stride_q <= '0;
            rem_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            stride_q <= stride_d;
            rem_q    <= rem_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
        end
    end

    assign bram_addr  = addr_q;
    assign bram_wdata = wdata_q;
    assign bram_we    = we_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign drop_err   = drop_q;

`ifdef ACT_OUT_CKSUM_EN
    logic [DESIGN_SIZE*DWIDTH-1:0] cksum_q, cksum_d, masked_data;
    logic                          arm, accept;

    assign arm    = (state_q == StIdle) && start;
    assign accept = (state_q == StRun) && in_data_available;

    always_comb begin
        masked_data = '0;
        for (int i = 0; i < DESIGN_SIZE; i++) begin
            if (validity_mask[i]) begin
                masked_data[i*DWIDTH +: DWIDTH] = in_data[i*DWIDTH +: DWIDTH];
            end
        end
        cksum_d = cksum_q;
        if (arm) begin
            cksum_d = '0;
        end else if (accept) begin
            cksum_d = cksum_q ^ masked_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cksum_q <= '0;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign checksum = cksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_act_out_writer.sv
// Self-checking bench for act_out_writer: cycle-stepped reference model feeding a write scoreboard.
module tb_act_out_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [9:0]  addr_stride;
    logic [7:0]  num_vectors;
    logic [31:0] in_data;
    logic        in_data_available;
    logic [3:0]  validity_mask;
    logic [9:0]  bram_addr;
    logic [31:0] bram_wdata;
    logic [3:0]  bram_we;
    logic        busy;
    logic        done;
    logic        drop_err;
    logic [31:0] checksum;

    act_out_writer #(
        .DWIDTH      (8),
        .DESIGN_SIZE (4),
        .AWIDTH      (10),
        .MASK_WIDTH  (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .base_addr         (base_addr),
        .addr_stride       (addr_stride),
        .num_vectors       (num_vectors),
        .in_data           (in_data),
        .in_data_available (in_data_available),
        .validity_mask     (validity_mask),
        .bram_addr         (bram_addr),
        .bram_wdata        (bram_wdata),
        .bram_we           (bram_we),
        .busy              (busy),
        .done              (done),
        .drop_err          (drop_err),
        .checksum          (checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        logic [3:0]  we;
    } wr_t;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model state: 0 idle, 1 run, 2 fin
    int          m_state;
    logic [9:0]  m_ptr;
    logic [9:0]  m_stride;
    logic [7:0]  m_rem;
    logic        m_drop;
    logic [31:0] m_cksum;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset(input logic av);
        reset             = 1'b1;
        start             = 1'b0;
        in_data_available = av;
        in_data           = 32'hDEADBEEF;
        validity_mask     = 4'hF;
        @(posedge clk); #1;
        check("rst_addr", bram_addr, 0);
        check("rst_wdata", bram_wdata, 0);
        check("rst_we", bram_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_drop", drop_err, 0);
        check("rst_cksum", checksum, 0);
        reset   = 1'b0;
        m_state = 0;
        m_ptr   = '0;
        m_stride = '0;
        m_rem   = '0;
        m_drop  = 1'b0;
        m_cksum = '0;
        exp_q.delete();
    endtask

    // Drive one cycle of inputs, advance the model, then compare outputs after the edge.
    task automatic cyc(input logic st, input logic [9:0] ba, input logic [9:0] sd,
                       input logic [7:0] num, input logic av, input logic [31:0] d,
                       input logic [3:0] m);
        wr_t         e;
        logic        pushed;
        logic [31:0] md;
        start             = st;
        base_addr         = ba;
        addr_stride       = sd;
        num_vectors       = num;
        in_data_available = av;
        in_data           = d;
        validity_mask     = m;
        pushed            = 1'b0;
        case (m_state)
            0: begin
                if (av) m_drop = 1'b1;
                if (st) begin
                    m_cksum = '0;
                    if (num != 0) begin
                        m_ptr    = ba;
                        m_stride = sd;
                        m_rem    = num;
                        m_state  = 1;
                    end else begin
                        m_state = 2;
                    end
                end
            end
            1: begin
                if (av) begin
                    e.addr = m_ptr;
                    e.data = d;
                    e.we   = m;
                    exp_q.push_back(e);
                    pushed = 1'b1;
                    md = '0;
                    for (int i = 0; i < 4; i++) if (m[i]) md[i*8 +: 8] = d[i*8 +: 8];
                    m_cksum = m_cksum ^ md;
                    m_ptr   = m_ptr + m_stride;
                    m_rem   = m_rem - 8'd1;
                    if (m_rem == 0) m_state = 2;
                end
            end
            default: begin
                if (av) m_drop = 1'b1;
                m_state = 0;
            end
        endcase
        @(posedge clk); #1;
        if (pushed) begin
            e = exp_q.pop_front();
            check("wr_addr", bram_addr, e.addr);
            check("wr_data", bram_wdata, e.data);
            check("wr_we", bram_we, e.we);
        end else begin
            check("we_quiet", bram_we, 0);
        end
        check("done", done, (m_state == 2));
        check("busy", busy, (m_state != 0));
        check("drop_err", drop_err, m_drop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 10'h0, 10'h0, 8'd0, 1'b0, $urandom, 4'hF);
    endtask

    task automatic check_cksum();
`ifdef ACT_OUT_CKSUM_EN
        check("cksum", checksum, m_cksum);
`else
        check("cksum_off", checksum, 0);
`endif
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        addr_stride = '0;
        num_vectors = '0;
        in_data = '0;
        in_data_available = 1'b0;
        validity_mask = '0;
        @(posedge clk); #1;
        do_reset(1'b0);

        // Basic back-to-back run
        cyc(1'b1, 10'h010, 10'd1, 8'd4, 1'b0, 32'h0, 4'h0);
        cyc(1'b0, 10'h0, 10'h0, 8'd0, 1'b1, 32'h04030201, 4'hF);
        cyc(1'b0, 10'h0, 10'h0, 8'd0, 1'b1, 32'h08070605, 4'hF);
        cyc(1'b0, 10'h0, 10'h0, 8'd0, 1'b1, 32'h0C0B0A09, 4'hF);
        cyc(1'b0, 10'h0, 10'h0, 8'd0, 1'b1, 32'h100F0E0D, 4'hF);
        idle(2);
        check_cksum();

        // Strided run with gaps, partial masks and address wrap
        cyc(1'b1, 10'h3FE, 10'd3, 8'd3, 1'b0, 32'h0, 4'h0);
        cyc(1'b0, 10'h0, 10'h0, 8'd0, 1'b1, 32'hA1B2C3D4, 4'h3);
        idle(2);
        cyc(1'b0, 10'h0, 10'h0, 8'd0, 1'b1, 32'h55667788, 4'h0);
        idle(2);
        cyc(1'b0, 10'h0, 10'h0, 8'd0, 1'b1, 32'h99AABBCC, 4'hC);
        idle(2);
        check_cksum();

        // Zero-count start
        cyc(1'b1, 10'h123, 10'd5, 8'd0, 1'b0, 32'h0, 4'h0);
        idle(2);

        // Drop in idle, then a one-beat run with restarts while busy
        cyc(1'b0, 10'h0, 10'h0, 8'd0, 1'b1, 32'hFFFFFFFF, 4'hF);
        cyc(1'b1, 10'h200, 10'd7, 8'd1, 1'b0, 32'h0, 4'h0);
        cyc(1'b1, 10'h050, 10'd1, 8'd9, 1'b1, 32'h13572468, 4'h5);
        cyc(1'b1, 10'h060, 10'd1, 8'd9, 1'b0, 32'h0, 4'h0);
        idle(2);
        check_cksum();

        // Same-cycle start and data: beat dropped, transfer still arms
        do_reset(1'b0);
        cyc(1'b1, 10'h100, 10'd2, 8'd2, 1'b1, 32'h11111111, 4'hF);
        for (int i = 0; i < 2; i++) cyc(1'b0, 10'h0, 10'h0, 8'd0, 1'b1, $urandom, 4'(i + 9));
        idle(2);
        check_cksum();

        // Reset mid-run
        do_reset(1'b0);
        cyc(1'b1, 10'h080, 10'd4, 8'd4, 1'b0, 32'h0, 4'h0);
        cyc(1'b0, 10'h0, 10'h0, 8'd0, 1'b1, $urandom, 4'hF);
        cyc(1'b0, 10'h0, 10'h0, 8'd0, 1'b1, $urandom, 4'hF);
        do_reset(1'b1);
        cyc(1'b0, 10'h0, 10'h0, 8'd0, 1'b1, $urandom, 4'hF);
        cyc(1'b0, 10'h0, 10'h0, 8'd0, 1'b1, $urandom, 4'hF);
        idle(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
